if_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register of the RISC-V pipeline, sitting directly upstream of the decoder.
- Owns the PC and issues word fetches to the instruction memory over a req/ready handshake.
- Absorbs memory wait states, hazard stalls and branch/jump redirects.
- Presents PC_id, Instruction_id and valid_id to ID; bubbles are NOP (addi x0,x0,0).

---
 rtl/if_stage_if.sv | 23 ++
 rtl/if_stage.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory fetch channel between the IF stage and instruction memory.
// Ports: imem_req/imem_addr from the fetch side; imem_rdata/imem_ready from memory.
// A fetch completes in any cycle where imem_req and imem_ready are both high.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_stage.sv
// Purpose: RISC-V instruction fetch stage with PC, one-entry skid buffer and IF/ID register.
// Latency: with imem_ready high, the word at imem_addr=A appears on Instruction_id one edge later.
// Backpressure: stall holds IF/ID (a completed fetch is parked in the skid buffer); memory
//   wait states insert bubbles; redirect flushes IF/ID and refetches from the target.
// Ports: clk, reset (sync, active-high); stall, redirect, redirect_pc from hazard/EX;
//   imem (master modport) to instruction memory; PC_id, Instruction_id, valid_id to decode.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  if_stage_if.master   imem,
  output logic [31:0]  PC_id,
  output logic [31:0]  Instruction_id,
  output logic         valid_id
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_DROP = 2'd1,   // redirect seen while a fetch was outstanding; its data will be discarded
    S_HOLD = 2'd2    // fetched word parked in the skid buffer while ID is stalled
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;

  logic [31:0] rd_tgt;
  logic [31:0] pc_inc;

  assign rd_tgt = redirect_pc & ~32'd3;
  assign pc_inc = pc_q + 32'd4;   // wraps modulo 2^32

  // In DROP the old address stays on the bus until memory completes it.
  assign imem.imem_req  = ~reset & (state_q != S_HOLD);
  assign imem.imem_addr = pc_q;

  assign PC_id          = pc_id_q;
  assign Instruction_id = instr_id_q;
  assign valid_id       = valid_id_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    pc_id_d      = pc_id_q;
    instr_id_d   = instr_id_q;
    valid_id_d   = valid_id_q;

    case (state_q)
      S_RUN: begin
        if (redirect) begin
          if (imem.imem_ready) begin
            pc_d = rd_tgt;
          end else begin
            tgt_d   = rd_tgt;
            state_d = S_DROP;
          end
        end else if (stall) begin
          if (imem.imem_ready) begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem.imem_rdata;
            pc_d         = pc_inc;
            state_d      = S_HOLD;
          end
        end else if (imem.imem_ready) begin
          pc_id_d    = pc_q;
          instr_id_d = imem.imem_rdata;
          valid_id_d = 1'b1;
          pc_d       = pc_inc;
        end else begin
          instr_id_d = NOP_INSTR;
          valid_id_d = 1'b0;
        end
      end

      S_DROP: begin
        if (redirect) begin
          tgt_d = rd_tgt;
        end
        if (imem.imem_ready) begin
          // A redirect on the completing edge is the latest target and wins.
          pc_d    = redirect ? rd_tgt : tgt_q;
          state_d = S_RUN;
        end
        if (!stall) begin
          instr_id_d = NOP_INSTR;
          valid_id_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = rd_tgt;
          state_d = S_RUN;
        end else if (!stall) begin
          pc_id_d    = skid_pc_q;
          instr_id_d = skid_instr_q;
          valid_id_d = 1'b1;
          state_d    = S_RUN;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    // Redirect flushes IF/ID from any state; PC_id is left as it was.
    if (redirect) begin
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      tgt_q        <= 32'd0;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= 32'd0;
      pc_id_q      <= 32'd0;
      instr_id_q   <= NOP_INSTR;
      valid_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      pc_id_q      <= pc_id_d;
      instr_id_q   <= instr_id_d;
      valid_id_q   <= valid_id_d;
    end
  end

endmodule
